nn_param_loader: RTL and testbench

// - Streams trained weights and biases into neural_network before inference; drives its i_weight/i_bias/i_layer_id/i_neuron_id bus.
// - Sits upstream of the network on the config path; consumes one 32-bit AXI-stream parameter image per load.
// - Image order: layer 1..N_LAYERS, neuron 0..Lk_NEURONS-1, per neuron Lk_WEIGHTS weights then 1 bias.

---
 rtl/nn_param_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_nn_param_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_param_loader.sv
// rtl/nn_param_loader.sv - streams a 32-bit parameter image into the network weight/bias bus
// Optional trailing-checksum check enabled by defining NN_PARAM_CHECKSUM_EN.
module nn_param_loader #(
    parameter int N_LAYERS   = 4,
    parameter int L1_NEURONS = 30,
    parameter int L1_WEIGHTS = 784,
    parameter int L2_NEURONS = 30,
    parameter int L2_WEIGHTS = 30,
    parameter int L3_NEURONS = 10,
    parameter int L3_WEIGHTS = 30,
    parameter int L4_NEURONS = 10,
    parameter int L4_WEIGHTS = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_s_axis_data,
    input  logic        i_s_axis_valid,
    input  logic        i_s_axis_last,
    output logic        o_s_axis_ready,
    output logic [31:0] o_weight,
    output logic        o_weight_valid,
    output logic [31:0] o_bias,
    output logic        o_bias_valid,
    output logic [31:0] o_layer_id,
    output logic [31:0] o_neuron_id,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_W   = max2(max2(L1_WEIGHTS, L2_WEIGHTS), max2(L3_WEIGHTS, L4_WEIGHTS));
    localparam int MAX_N   = max2(max2(L1_NEURONS, L2_NEURONS), max2(L3_NEURONS, L4_NEURONS));
    localparam int WCNT_W  = $clog2(MAX_W + 1);
    localparam int NRN_W   = $clog2(MAX_N + 1);
    localparam int LAYER_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic [LAYER_W-1:0] layer;
    logic [NRN_W-1:0]   neuron;
    logic [WCNT_W-1:0]  wcnt;
    logic [NRN_W-1:0]   cur_neurons;
    logic [WCNT_W-1:0]  cur_weights;

    logic xfer;
    logic last_weight;
    logic last_neuron;
    logic last_layer;
    logic final_bias;
    logic expect_last;
    logic frame_err;
    logic fwd;
    logic start_load;

    always_comb begin
        cur_neurons = NRN_W'(L1_NEURONS);
        cur_weights = WCNT_W'(L1_WEIGHTS);
        case (layer)
            3'd2: begin
                cur_neurons = NRN_W'(L2_NEURONS);
                cur_weights = WCNT_W'(L2_WEIGHTS);
            end
            3'd3: begin
                cur_neurons = NRN_W'(L3_NEURONS);
                cur_weights = WCNT_W'(L3_WEIGHTS);
            end
            3'd4: begin
                cur_neurons = NRN_W'(L4_NEURONS);
                cur_weights = WCNT_W'(L4_WEIGHTS);
            end
            default: begin
                cur_neurons = NRN_W'(L1_NEURONS);
                cur_weights = WCNT_W'(L1_WEIGHTS);
            end
        endcase
    end

    assign o_s_axis_ready = (state == S_WEIGHT) || (state == S_BIAS) || (state == S_CHECK);
    assign o_busy         = o_s_axis_ready;

    assign xfer        = i_s_axis_valid && o_s_axis_ready;
    assign start_load  = (state == S_IDLE) && i_start;
    assign last_weight = (wcnt == cur_weights - WCNT_W'(1));
    assign last_neuron = (neuron == cur_neurons - NRN_W'(1));
    assign last_layer  = (layer == LAYER_W'(N_LAYERS));
    assign final_bias  = (state == S_BIAS) && last_neuron && last_layer;

`ifdef NN_PARAM_CHECKSUM_EN
    logic [31:0] csum;
    logic        csum_match;

    // With the checksum trailer present, only the trailer may carry last.
    assign expect_last = (state == S_CHECK);
    assign csum_match  = (i_s_axis_data == csum);

    always_ff @(posedge i_clk) begin
        if (i_reset || start_load) begin
            csum <= '0;
        end else if (fwd) begin
            csum <= csum + i_s_axis_data;
        end
    end
`else
    assign expect_last = final_bias;
`endif

    assign frame_err = xfer && (i_s_axis_last != expect_last);
    assign fwd       = xfer && !frame_err && ((state == S_WEIGHT) || (state == S_BIAS));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start) state_next = S_WEIGHT;
            end
            S_WEIGHT: begin
                if (xfer) begin
                    if (frame_err)        state_next = S_ERROR;
                    else if (last_weight) state_next = S_BIAS;
                end
            end
            S_BIAS: begin
                if (xfer) begin
                    if (frame_err) begin
                        state_next = S_ERROR;
                    end else if (final_bias) begin
`ifdef NN_PARAM_CHECKSUM_EN
                        state_next = S_CHECK;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_WEIGHT;
                    end
                end
            end
            S_CHECK: begin
`ifdef NN_PARAM_CHECKSUM_EN
                if (xfer) begin
                    if (frame_err || !csum_match) state_next = S_ERROR;
                    else                          state_next = S_DONE;
                end
`else
                state_next = S_ERROR;
`endif
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            layer          <= '0;
            neuron         <= '0;
            wcnt           <= '0;
            o_weight       <= '0;
            o_weight_valid <= 1'b0;
            o_bias         <= '0;
            o_bias_valid   <= 1'b0;
            o_layer_id     <= '0;
            o_neuron_id    <= '0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_weight_valid <= 1'b0;
            o_bias_valid   <= 1'b0;

            if (start_load) begin
                layer   <= LAYER_W'(1);
                neuron  <= '0;
                wcnt    <= '0;
                o_done  <= 1'b0;
                o_error <= 1'b0;
            end

            if (fwd) begin
                o_layer_id  <= 32'(layer);
                o_neuron_id <= 32'(neuron);
                if (state == S_WEIGHT) begin
                    o_weight       <= i_s_axis_data;
                    o_weight_valid <= 1'b1;
                    wcnt           <= wcnt + WCNT_W'(1);
                end else begin
                    o_bias       <= i_s_axis_data;
                    o_bias_valid <= 1'b1;
                    wcnt         <= '0;
                    if (last_neuron) begin
                        neuron <= '0;
                        layer  <= layer + LAYER_W'(1);
                    end else begin
                        neuron <= neuron + NRN_W'(1);
                    end
                end
            end

            // Flags are sticky until the next start; DONE/ERROR only last one cycle.
            if (state_next == S_DONE)  o_done  <= 1'b1;
            if (state_next == S_ERROR) o_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nn_param_loader.sv
// tb/tb_nn_param_loader.sv - scoreboard bench for nn_param_loader
module tb_nn_param_loader;

    localparam int NL  = 2;
    localparam int L1N = 2;
    localparam int L1W = 2;
    localparam int L2N = 2;
    localparam int L2W = 3;
`ifdef NN_PARAM_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        o_s_axis_ready;
    logic [31:0] o_weight;
    logic        o_weight_valid;
    logic [31:0] o_bias;
    logic        o_bias_valid;
    logic [31:0] o_layer_id;
    logic [31:0] o_neuron_id;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    nn_param_loader #(
        .N_LAYERS(NL), .L1_NEURONS(L1N), .L1_WEIGHTS(L1W), .L2_NEURONS(L2N), .L2_WEIGHTS(L2W),
        .L3_NEURONS(10), .L3_WEIGHTS(30), .L4_NEURONS(10), .L4_WEIGHTS(10)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start),
        .i_s_axis_data(data), .i_s_axis_valid(valid), .i_s_axis_last(last),
        .o_s_axis_ready(o_s_axis_ready),
        .o_weight(o_weight), .o_weight_valid(o_weight_valid),
        .o_bias(o_bias), .o_bias_valid(o_bias_valid),
        .o_layer_id(o_layer_id), .o_neuron_id(o_neuron_id),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_bias;
        int layer;
        int neuron;
    } pos_t;

    typedef struct {
        bit          is_bias;
        logic [31:0] val;
        int          layer;
        int          neuron;
        int          cyc;
    } exp_t;

    pos_t        pos_q[$];
    exp_t        sbq[$];
    logic [31:0] img_w[$];
    bit          img_l[$];
    int          npos;
    int          exp_len;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_weight_valid || o_bias_valid) begin
            exp_t e;
            if (o_weight_valid && o_bias_valid) check("strobe_exclusive", 1, 0);
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got w=%0h b=%0h expected none", o_weight, o_bias);
            end else begin
                e = sbq.pop_front();
                check("strobe_kind", 32'(o_bias_valid), 32'(e.is_bias));
                check("strobe_data", o_bias_valid ? o_bias : o_weight, e.val);
                check("layer_id", o_layer_id, 32'(e.layer));
                check("neuron_id", o_neuron_id, 32'(e.neuron));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic make_image(input bit rnd, input int bad_last, input bit bad_sum);
        logic [31:0] s;
        logic [31:0] v;
        s = 0;
        img_w.delete();
        img_l.delete();
        for (int i = 0; i < npos; i++) begin
            v = rnd ? $urandom : 32'(i + 1);
            img_w.push_back(v);
            img_l.push_back(1'b0);
            s += v;
        end
        if (CS != 0) begin
            img_w.push_back(bad_sum ? s + 1 : s);
            img_l.push_back(1'b0);
        end
        img_l[exp_len-1] = 1'b1;
        if (bad_last >= 0) img_l[bad_last] = !img_l[bad_last];
    endtask

    // gap < 0: random idle cycles between words; otherwise fixed idle cycles.
    task automatic run_load(input int gap, input int start_at, input int reset_after);
        bit          exp_err;
        bit          finished;
        bit          fin;
        logic [31:0] sum;
        int          n;
        int          wait_n;
        int          g;
        exp_t        e;
        exp_err  = 0;
        finished = 0;
        sum      = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 1);
        for (int i = 0; i < img_w.size() && !finished; i++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) @(negedge clk);
            valid   = 1'b1;
            data    = img_w[i];
            last    = img_l[i];
            i_start = (i == start_at);
            wait_n  = 0;
            while (!o_s_axis_ready && wait_n < 50) begin
                @(negedge clk);
                wait_n++;
            end
            if (!o_s_axis_ready) begin
                fail_now("ready_timeout");
                valid   = 1'b0;
                i_start = 1'b0;
                return;
            end
            n   = cyc;
            fin = (i == exp_len - 1);
            if (img_l[i] != fin) begin
                exp_err  = 1;
                finished = 1;
            end else if (i < npos) begin
                e.is_bias = pos_q[i].is_bias;
                e.val     = img_w[i];
                e.layer   = pos_q[i].layer;
                e.neuron  = pos_q[i].neuron;
                e.cyc     = n + 1;
                sbq.push_back(e);
                sum += img_w[i];
                if (fin) finished = 1;
            end else begin
                exp_err  = (img_w[i] != sum);
                finished = 1;
            end
            @(negedge clk);
            valid   = 1'b0;
            last    = 1'b0;
            i_start = 1'b0;
            if (finished) check("ready_drop", 32'(o_s_axis_ready), 0);
            if (i + 1 == reset_after) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_weight_valid", 32'(o_weight_valid), 0);
                check("rst_bias_valid", 32'(o_bias_valid), 0);
                check("rst_weight", o_weight, 0);
                check("rst_bias", o_bias, 0);
                check("rst_layer_id", o_layer_id, 0);
                check("rst_neuron_id", o_neuron_id, 0);
                check("rst_busy", 32'(o_busy), 0);
                check("rst_ready", 32'(o_s_axis_ready), 0);
                check("rst_done", 32'(o_done), 0);
                check("rst_pending", 32'(sbq.size()), 0);
                sbq.delete();
                rst = 1'b0;
                repeat (3) @(negedge clk);
                return;
            end
        end
        repeat (3) @(negedge clk);
        check("done", 32'(o_done), 32'(!exp_err));
        check("error", 32'(o_error), 32'(exp_err));
        check("busy_idle", 32'(o_busy), 0);
        check("ready_idle", 32'(o_s_axis_ready), 0);
        check("pending", 32'(sbq.size()), 0);
        sbq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pos_t p;
        int   nn;
        int   nw;
        for (int l = 1; l <= NL; l++) begin
            nn = (l == 1) ? L1N : L2N;
            nw = (l == 1) ? L1W : L2W;
            for (int n = 0; n < nn; n++) begin
                for (int k = 0; k <= nw; k++) begin
                    p.is_bias = (k == nw);
                    p.layer   = l;
                    p.neuron  = n;
                    pos_q.push_back(p);
                end
            end
        end
        npos    = pos_q.size();
        exp_len = npos + CS;

        rst = 1'b1; i_start = 1'b0; data = '0; valid = 1'b0; last = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_weight_valid", 32'(o_weight_valid), 0);
        check("reset_bias_valid", 32'(o_bias_valid), 0);
        check("reset_layer_id", o_layer_id, 0);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_ready", 32'(o_s_axis_ready), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_error", 32'(o_error), 0);
        rst = 1'b0;
        @(negedge clk);

        make_image(0, -1, 0);
        run_load(0, -1, -1);
        run_load(1, -1, -1);
        make_image(0, 4, 0);
        run_load(0, -1, -1);
        make_image(0, -1, 0);
        run_load(0, -1, 7);
        run_load(0, -1, -1);
        run_load(0, 2, -1);
        if (CS != 0) begin
            make_image(0, -1, 1);
            run_load(0, -1, -1);
        end
        make_image(0, exp_len - 1, 0);
        run_load(0, -1, -1);

        for (int r = 0; r < 12; r++) begin
            make_image(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_len - 1)) : -1,
                       ($urandom_range(0, 3) == 0));
            run_load(-1, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, npos - 1)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
